tx_resp_arbiter: RTL

- Shares the single UART TX path (TX async FIFO write port) between two response sources: register-file read data and ALU results.
- Sits between the register file / ALU and the TX FIFO, alongside the system controller.
- Buffers one pending response per source and serialises the 16-bit ALU result into two bytes.
- Throttles on FIFO_full and signals busy/drop back to the controller.

---
 rtl/tx_resp_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/tx_resp_arbiter.sv
// rtl/tx_resp_arbiter.sv - shares the UART TX FIFO write port between register read data and ALU results
// Optional RESP_RR_EN: round-robin between the RD and ALU slots instead of fixed RD-over-ALU priority.
module tx_resp_arbiter #(
    parameter int Data_width = 8,
    parameter int ALU_width  = 2 * Data_width
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [Data_width-1:0] Rd_data,
    input  logic                  RdData_valid,
    input  logic [ALU_width-1:0]  ALU_OUT,
    input  logic                  OUT_VALID,
    input  logic                  FIFO_full,
    output logic [Data_width-1:0] TX_p_data,
    output logic                  TX_d_valid,
    output logic                  busy,
    output logic                  drop_err
);
    typedef enum logic [1:0] {IDLE, SEND_RD, SEND_ALU_LO, SEND_ALU_HI} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [Data_width-1:0] r_rd_data;
    logic [Data_width-1:0] r_tx_data;
    logic [Data_width-1:0] w_tx_data_nxt;
    logic [ALU_width-1:0]  r_alu_data;
    logic                  r_rd_pend;
    logic                  r_alu_pend;
    logic                  r_tx_valid;
    logic                  r_drop;
    logic                  w_emit;
    logic                  w_rd_free;
    logic                  w_alu_free;
    logic                  w_rd_load;
    logic                  w_alu_load;
    logic                  w_drop;
    logic                  w_pick_alu;

`ifdef RESP_RR_EN
    logic r_last_alu;

    // Reset value favours RD on the first contested grant.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_last_alu <= 1'b1;
        end else if (w_rd_free) begin
            r_last_alu <= 1'b0;
        end else if (w_alu_free) begin
            r_last_alu <= 1'b1;
        end
    end

    assign w_pick_alu = r_alu_pend && (!r_rd_pend || !r_last_alu);
`else
    assign w_pick_alu = r_alu_pend && !r_rd_pend;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_emit        = 1'b0;
        w_tx_data_nxt = r_tx_data;
        w_rd_free     = 1'b0;
        w_alu_free    = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_rd_pend || r_alu_pend) begin
                    w_state_nxt = w_pick_alu ? SEND_ALU_LO : SEND_RD;
                end
            end
            SEND_RD: begin
                if (!FIFO_full) begin
                    w_emit        = 1'b1;
                    w_tx_data_nxt = r_rd_data;
                    w_rd_free     = 1'b1;
                    w_state_nxt   = IDLE;
                end
            end
            SEND_ALU_LO: begin
                if (!FIFO_full) begin
                    w_emit        = 1'b1;
                    w_tx_data_nxt = r_alu_data[Data_width-1:0];
                    w_state_nxt   = SEND_ALU_HI;
                end
            end
            SEND_ALU_HI: begin
                if (!FIFO_full) begin
                    w_emit        = 1'b1;
                    w_tx_data_nxt = r_alu_data[ALU_width-1:Data_width];
                    w_alu_free    = 1'b1;
                    w_state_nxt   = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // A slot emptied on this edge may take the new strobe without a drop.
    assign w_rd_load  = RdData_valid && (!r_rd_pend || w_rd_free);
    assign w_alu_load = OUT_VALID && (!r_alu_pend || w_alu_free);
    assign w_drop     = (RdData_valid && !w_rd_load) || (OUT_VALID && !w_alu_load);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= IDLE;
            r_rd_data  <= '0;
            r_alu_data <= '0;
            r_rd_pend  <= 1'b0;
            r_alu_pend <= 1'b0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_valid <= w_emit;
            r_drop     <= w_drop;
            if (w_rd_load) begin
                r_rd_pend <= 1'b1;
                r_rd_data <= Rd_data;
            end else if (w_rd_free) begin
                r_rd_pend <= 1'b0;
            end
            if (w_alu_load) begin
                r_alu_pend <= 1'b1;
                r_alu_data <= ALU_OUT;
            end else if (w_alu_free) begin
                r_alu_pend <= 1'b0;
            end
        end
    end

    assign TX_p_data  = r_tx_data;
    assign TX_d_valid = r_tx_valid;
    assign drop_err   = r_drop;
    assign busy       = r_rd_pend | r_alu_pend | (r_state != IDLE);

endmodule
